// File: rtl/unified_mem_arbiter_pkg.sv
// Shared encodings for the unified memory arbiter: read-return owner and grant selection.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_IF,
    GNT_DM
  } grant_t;

endpackage

// File: rtl/unified_mem_arbiter_pick.sv
// Combinational grant selection between instruction fetch and data memory requests.
module mem_arb_pick
  import unified_mem_arbiter_pkg::*;
(
  input  logic   if_rd,
  input  logic   dm_req,
  input  logic   starve_full,
  output grant_t gnt
);

  // DM normally wins; a starved fetch takes the slot once the DM streak hits its limit.
  always_comb begin
    gnt = GNT_NONE;
    if (dm_req && !(if_rd && starve_full)) begin
      gnt = GNT_DM;
    end else if (if_rd) begin
      gnt = GNT_IF;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port synchronous memory between the fetch port and the data port,
// returning read data one cycle after grant and stalling the losing requester.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_rd,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_valid,
  output logic                  stall_if,
  input  logic                  dm_rd,
  input  logic                  dm_wr,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_valid,
  output logic                  stall_mem,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  err_rdwr
);

  localparam int unsigned CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [CNT_W-1:0]      starve_cnt, starve_next;
  logic [DATA_WIDTH-1:0] if_hold, dm_hold;
  logic                  dm_req, starve_full, ret_if, ret_dm;
  grant_t                gnt;
  owner_t                owner, owner_next;

  assign dm_req      = dm_rd | dm_wr;
  assign starve_full = (starve_cnt == CNT_W'(STARVE_MAX));

  mem_arb_pick u_pick (
    .if_rd       (if_rd),
    .dm_req      (dm_req),
    .starve_full (starve_full),
    .gnt         (gnt)
  );

  assign stall_if  = if_rd  & (gnt != GNT_IF);
  assign stall_mem = dm_req & (gnt != GNT_DM);

  always_comb begin
    mem_en    = !rst && (gnt != GNT_NONE);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = dm_wdata;
    case (gnt)
      GNT_IF: mem_addr = if_addr;
      GNT_DM: begin
        mem_addr = dm_addr;
        mem_we   = mem_en & dm_wr;
      end
      default: mem_addr = '0;
    endcase
  end

  // A simultaneous rd+wr is performed as a write, so it never claims a read return.
  always_comb begin
    owner_next = OWN_NONE;
    case (gnt)
      GNT_IF:  owner_next = OWN_IF;
      GNT_DM:  owner_next = dm_wr ? OWN_NONE : OWN_DM;
      default: owner_next = OWN_NONE;
    endcase
  end

  always_comb begin
    starve_next = starve_cnt;
    if (!if_rd || gnt == GNT_IF) begin
      starve_next = '0;
    end else if (gnt == GNT_DM && !starve_full) begin
      starve_next = starve_cnt + 1'b1;
    end
  end

  // Memory data arrives in the return cycle, so it is forwarded straight out while the
  // holding register keeps it for later cycles; reset suppresses a pending return.
  assign ret_if   = (owner == OWN_IF) && !rst;
  assign ret_dm   = (owner == OWN_DM) && !rst;
  assign if_valid = ret_if;
  assign dm_valid = ret_dm;
  assign if_rdata = ret_if ? mem_rdata : if_hold;
  assign dm_rdata = ret_dm ? mem_rdata : dm_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= OWN_NONE;
      starve_cnt <= '0;
      if_hold    <= '0;
      dm_hold    <= '0;
      err_rdwr   <= 1'b0;
    end else begin
      owner      <= owner_next;
      starve_cnt <= starve_next;
      if (ret_if) if_hold <= mem_rdata;
      if (ret_dm) dm_hold <= mem_rdata;
      if (dm_rd && dm_wr) err_rdwr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomised and directed bench for unified_mem_arbiter against a transaction-level model.
module tb_unified_mem_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int SMAX = 3;

  logic          clk = 1'b0;
  logic          rst, if_rd, dm_rd, dm_wr;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [DW-1:0] dm_wdata, if_rdata, dm_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          if_valid, dm_valid, stall_if, stall_mem, mem_en, mem_we, err_rdwr;

  int checks = 0;
  int errors = 0;

  unified_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_rd(if_rd), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .stall_if(stall_if),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .stall_mem(stall_mem),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err_rdwr(err_rdwr)
  );

  always #5 clk = ~clk;

  // Memory the DUT talks to (environment)
  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // Transaction-level model: DM streak length while IF waits, pending return, held data
  int            m_streak = 0;
  int            m_pend   = 0;   // 0 none, 1 fetch, 2 data
  logic [DW-1:0] m_pend_data = '0, m_hold_if = '0, m_hold_dm = '0;
  bit            m_err = 1'b0;

  int            e_gnt;
  bit            e_stall_if, e_stall_mem, e_mem_en, e_mem_we, e_if_valid, e_dm_valid, e_err;
  logic [AW-1:0] e_mem_addr;
  logic [DW-1:0] e_mem_wdata, e_if_rdata, e_dm_rdata;

  task automatic drive(input bit r, input bit ir, input logic [AW-1:0] ia,
                       input bit dr, input bit dw, input logic [AW-1:0] da, input logic [DW-1:0] wd);
    bit dmq;
    @(negedge clk);
    rst = r; if_rd = ir; if_addr = ia; dm_rd = dr; dm_wr = dw; dm_addr = da; dm_wdata = wd;
    #1;
    dmq = dr | dw;
    if (ir && dmq)  e_gnt = (m_streak >= SMAX) ? 1 : 2;
    else if (ir)    e_gnt = 1;
    else if (dmq)   e_gnt = 2;
    else            e_gnt = 0;
    e_stall_if  = ir  && (e_gnt != 1);
    e_stall_mem = dmq && (e_gnt != 2);
    e_mem_en    = !r && (e_gnt != 0);
    e_mem_we    = e_mem_en && (e_gnt == 2) && dw;
    e_mem_addr  = (e_gnt == 1) ? ia : da;
    e_mem_wdata = wd;
    e_if_valid  = !r && (m_pend == 1);
    e_dm_valid  = !r && (m_pend == 2);
    e_if_rdata  = e_if_valid ? m_pend_data : m_hold_if;
    e_dm_rdata  = e_dm_valid ? m_pend_data : m_hold_dm;
    e_err       = m_err;
    if (r) begin
      m_streak = 0; m_pend = 0; m_hold_if = '0; m_hold_dm = '0; m_err = 1'b0;
    end else begin
      if (e_if_valid) m_hold_if = m_pend_data;
      if (e_dm_valid) m_hold_dm = m_pend_data;
      if (dr && dw) m_err = 1'b1;
      m_pend = 0;
      if (e_gnt == 1) begin
        m_pend = 1; m_pend_data = ref_mem[ia];
      end else if (e_gnt == 2 && !dw) begin
        m_pend = 2; m_pend_data = ref_mem[da];
      end else if (e_gnt == 2) begin
        ref_mem[da] = wd;
      end
      if (!ir || e_gnt == 1) m_streak = 0;
      else if (e_gnt == 2 && m_streak < SMAX) m_streak++;
    end
  endtask

  task automatic idle(input bit r);
    drive(r, 1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset;
    idle(1'b1);
    drive(1'b1, 1'b1, 8'h05, 1'b1, 1'b0, 8'h06, '0);
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en got=%b exp=0", mem_en); end
    idle(1'b0);
    checks++; if (if_valid !== 1'b0 || dm_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b%b exp=00", if_valid, dm_valid); end
    checks++; if (if_rdata !== '0 || dm_rdata !== '0) begin errors++; $display("FAIL rst_rdata got=%h/%h exp=0/0", if_rdata, dm_rdata); end
    checks++; if (err_rdwr !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err_rdwr); end
  endtask

  task automatic test_if_only;
    drive(1'b0, 1'b1, 8'h10, 1'b0, 1'b0, '0, '0);
    checks++; if (mem_en !== 1'b1 || stall_if !== 1'b0) begin errors++; $display("FAIL if_grant got en=%b stall=%b exp en=1 stall=0", mem_en, stall_if); end
    checks++; if (mem_addr !== 8'h10 || mem_we !== 1'b0) begin errors++; $display("FAIL if_memaddr got=%h we=%b exp=10 we=0", mem_addr, mem_we); end
    idle(1'b0);
    checks++; if (if_valid !== 1'b1 || if_rdata !== 16'hA5A5) begin errors++; $display("FAIL if_return got v=%b d=%h exp v=1 d=a5a5", if_valid, if_rdata); end
    idle(1'b0);
    checks++; if (if_valid !== 1'b0 || if_rdata !== 16'hA5A5) begin errors++; $display("FAIL if_hold got v=%b d=%h exp v=0 d=a5a5", if_valid, if_rdata); end
  endtask

  task automatic test_contention;
    drive(1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 8'h20, '0);
    checks++; if (stall_if !== 1'b1 || stall_mem !== 1'b0 || mem_addr !== 8'h20) begin errors++; $display("FAIL cont_grant got si=%b sm=%b a=%h exp 1 0 20", stall_if, stall_mem, mem_addr); end
    drive(1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 8'h20, '0);
    checks++; if (dm_valid !== 1'b1 || dm_rdata !== 16'h2020) begin errors++; $display("FAIL cont_dm_ret got v=%b d=%h exp v=1 d=2020", dm_valid, dm_rdata); end
    checks++; if (stall_if !== 1'b0 || mem_addr !== 8'h11) begin errors++; $display("FAIL cont_if_grant got si=%b a=%h exp 0 11", stall_if, mem_addr); end
    idle(1'b0);
    checks++; if (if_valid !== 1'b1 || if_rdata !== 16'h1111) begin errors++; $display("FAIL cont_if_ret got v=%b d=%h exp v=1 d=1111", if_valid, if_rdata); end
  endtask

  task automatic test_starvation;
    bit if_wins [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    idle(1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 8'h20, '0);
      checks++; if (stall_mem !== if_wins[i] || stall_if !== !if_wins[i]) begin errors++; $display("FAIL starve_seq i=%0d got sm=%b si=%b exp sm=%b", i, stall_mem, stall_if, if_wins[i]); end
    end
    idle(1'b0);
    idle(1'b0);
  endtask

  task automatic test_write_read;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 8'h30, 16'h1234);
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 16'h1234 || stall_mem !== 1'b0) begin errors++; $display("FAIL wr_drive got en=%b we=%b d=%h sm=%b exp 1 1 1234 0", mem_en, mem_we, mem_wdata, stall_mem); end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 8'h30, '0);
    checks++; if (dm_valid !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL wr_novalid got v=%b we=%b exp 0 0", dm_valid, mem_we); end
    idle(1'b0);
    checks++; if (dm_valid !== 1'b1 || dm_rdata !== 16'h1234) begin errors++; $display("FAIL wr_readback got v=%b d=%h exp v=1 d=1234", dm_valid, dm_rdata); end
  endtask

  task automatic test_rdwr_err;
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 8'h40, 16'hBEEF);
    checks++; if (mem_we !== 1'b1 || err_rdwr !== 1'b0) begin errors++; $display("FAIL rdwr_drive got we=%b err=%b exp 1 0", mem_we, err_rdwr); end
    idle(1'b0);
    checks++; if (dm_valid !== 1'b0 || err_rdwr !== 1'b1) begin errors++; $display("FAIL rdwr_err got v=%b err=%b exp 0 1", dm_valid, err_rdwr); end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 8'h40, '0);
    idle(1'b0);
    checks++; if (dm_rdata !== 16'hBEEF || err_rdwr !== 1'b1) begin errors++; $display("FAIL rdwr_sticky got d=%h err=%b exp beef 1", dm_rdata, err_rdwr); end
  endtask

  task automatic test_reset_mid;
    drive(1'b0, 1'b1, 8'h10, 1'b0, 1'b0, '0, '0);
    idle(1'b1);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", if_valid); end
    idle(1'b0);
    checks++; if (if_rdata !== '0 || if_valid !== 1'b0 || err_rdwr !== 1'b0) begin errors++; $display("FAIL rstmid_clear got d=%h v=%b err=%b exp 0 0 0", if_rdata, if_valid, err_rdwr); end
    drive(1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 8'h20, '0);
    checks++; if (stall_if !== 1'b1 || stall_mem !== 1'b0) begin errors++; $display("FAIL rstmid_starve got si=%b sm=%b exp 1 0", stall_if, stall_mem); end
  endtask

  task automatic test_random;
    bit r, ir, dr, dw;
    for (int c = 0; c < 400; c++) begin
      r  = ($urandom_range(0, 49) == 0);
      ir = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 2) == 0);
      dw = ($urandom_range(0, 3) == 0);
      drive(r, ir, AW'($urandom_range(0, 15)), dr, dw, AW'($urandom_range(0, 15)), DW'($urandom));
      checks++; if (mem_en !== e_mem_en || mem_we !== e_mem_we) begin errors++; $display("FAIL rnd_mem c=%0d got en=%b we=%b exp en=%b we=%b", c, mem_en, mem_we, e_mem_en, e_mem_we); end
      if (e_mem_en) begin
        checks++; if (mem_addr !== e_mem_addr) begin errors++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, mem_addr, e_mem_addr); end
      end
      if (e_mem_we) begin
        checks++; if (mem_wdata !== e_mem_wdata) begin errors++; $display("FAIL rnd_wdata c=%0d got=%h exp=%h", c, mem_wdata, e_mem_wdata); end
      end
      if (!r) begin
        checks++; if (stall_if !== e_stall_if || stall_mem !== e_stall_mem) begin errors++; $display("FAIL rnd_stall c=%0d got si=%b sm=%b exp si=%b sm=%b", c, stall_if, stall_mem, e_stall_if, e_stall_mem); end
      end
      checks++; if (if_valid !== e_if_valid || if_rdata !== e_if_rdata) begin errors++; $display("FAIL rnd_if c=%0d got v=%b d=%h exp v=%b d=%h", c, if_valid, if_rdata, e_if_valid, e_if_rdata); end
      checks++; if (dm_valid !== e_dm_valid || dm_rdata !== e_dm_rdata) begin errors++; $display("FAIL rnd_dm c=%0d got v=%b d=%h exp v=%b d=%h", c, dm_valid, dm_rdata, e_dm_valid, e_dm_rdata); end
      checks++; if (err_rdwr !== e_err) begin errors++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, err_rdwr, e_err); end
    end
  endtask

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < 256; i++) begin
      v = DW'($urandom);
      mem[i] = v; ref_mem[i] = v;
    end
    mem[8'h10] = 16'hA5A5; ref_mem[8'h10] = 16'hA5A5;
    mem[8'h11] = 16'h1111; ref_mem[8'h11] = 16'h1111;
    mem[8'h20] = 16'h2020; ref_mem[8'h20] = 16'h2020;
    rst = 1'b1; if_rd = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    test_reset;
    test_if_only;
    test_contention;
    test_starvation;
    test_write_read;
    test_rdwr_err;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
